// File: rtl/approx_mult_err_monitor.sv
// ============================================================================
// approx_mult_err_monitor : error-distance statistics for 8x8 approx multipliers
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module approx_mult_err_monitor #(
  parameter int CNT_W = 16,
  parameter int SUM_W = 32  // must be >= 16 so one ED always fits the adder
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] win_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic [15:0]      in_r,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [SUM_W-1:0] sum_ed,
  output logic [15:0]      max_ed
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] win_len_q, win_len_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic             drain_cnt_q, drain_cnt_d;

  logic             v1_q, v1_d;
  logic [15:0]      p1_q, p1_d;
  logic [15:0]      r1_q, r1_d;
  logic             v2_q, v2_d;
  logic [15:0]      ed2_q, ed2_d;
  logic             nz2_q, nz2_d;

  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [SUM_W-1:0] sum_ed_q, sum_ed_d;
  logic [15:0]      max_ed_q, max_ed_d;

  logic             accept;
  logic             clear_stats;
  logic [15:0]      prod;
  logic [SUM_W:0]   sum_ext;

  assign in_ready   = (state_q == RUN);
  assign busy       = (state_q == RUN) || (state_q == DRAIN);
  assign done       = (state_q == DONE);
  assign accept     = in_valid && in_ready;
  assign prod       = {8'd0, in_a} * {8'd0, in_b};

  assign sample_cnt = sample_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign sum_ed     = sum_ed_q;
  assign max_ed     = max_ed_q;

  // Control: window sequencing and accepted-sample counting
  always_comb begin
    state_d     = state_q;
    win_len_d   = win_len_q;
    acc_cnt_d   = acc_cnt_q;
    drain_cnt_d = drain_cnt_q;
    clear_stats = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          clear_stats = 1'b1;
          win_len_d   = win_len;
          acc_cnt_d   = '0;
          state_d     = (win_len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (accept) begin
          acc_cnt_d = acc_cnt_q + CNT_W'(1);
          if (acc_cnt_q == win_len_q - CNT_W'(1)) begin
            state_d     = DRAIN;
            drain_cnt_d = 1'b0;
          end
        end
      end
      DRAIN: begin
        drain_cnt_d = 1'b1;
        if (drain_cnt_q) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: exact product, error distance, statistics
  always_comb begin
    v1_d  = accept;
    p1_d  = p1_q;
    r1_d  = r1_q;
    if (accept) begin
      p1_d = prod;
      r1_d = in_r;
    end

    v2_d  = v1_q;
    ed2_d = (p1_q >= r1_q) ? (p1_q - r1_q) : (r1_q - p1_q);
    nz2_d = (ed2_d != 16'd0);

    sample_cnt_d = sample_cnt_q;
    err_cnt_d    = err_cnt_q;
    sum_ed_d     = sum_ed_q;
    max_ed_d     = max_ed_q;
    sum_ext      = {1'b0, sum_ed_q} + {{(SUM_W + 1 - 16){1'b0}}, ed2_q};
    if (clear_stats) begin
      sample_cnt_d = '0;
      err_cnt_d    = '0;
      sum_ed_d     = '0;
      max_ed_d     = '0;
    end else if (v2_q) begin
      sample_cnt_d = sample_cnt_q + CNT_W'(1);
      err_cnt_d    = err_cnt_q + CNT_W'(nz2_q);
      sum_ed_d     = sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
      max_ed_d     = (ed2_q > max_ed_q) ? ed2_q : max_ed_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      win_len_q    <= '0;
      acc_cnt_q    <= '0;
      drain_cnt_q  <= 1'b0;
      v1_q         <= 1'b0;
      p1_q         <= '0;
      r1_q         <= '0;
      v2_q         <= 1'b0;
      ed2_q        <= '0;
      nz2_q        <= 1'b0;
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      sum_ed_q     <= '0;
      max_ed_q     <= '0;
    end else begin
      state_q      <= state_d;
      win_len_q    <= win_len_d;
      acc_cnt_q    <= acc_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      v1_q         <= v1_d;
      p1_q         <= p1_d;
      r1_q         <= r1_d;
      v2_q         <= v2_d;
      ed2_q        <= ed2_d;
      nz2_q        <= nz2_d;
      sample_cnt_q <= sample_cnt_d;
      err_cnt_q    <= err_cnt_d;
      sum_ed_q     <= sum_ed_d;
      max_ed_q     <= max_ed_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_approx_mult_err_monitor.sv
// ============================================================================
// tb_approx_mult_err_monitor : directed bench with hand-computed statistics
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_approx_mult_err_monitor;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] win_len = '0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_a = '0;
  logic [7:0]       in_b = '0;
  logic [15:0]      in_r = '0;

  logic             in_ready, busy, done;
  logic [CNT_W-1:0] sample_cnt, err_cnt;
  logic [31:0]      sum_ed;
  logic [15:0]      max_ed;

  logic             in_ready_s, busy_s, done_s;
  logic [CNT_W-1:0] sample_cnt_s, err_cnt_s;
  logic [15:0]      sum_ed_s;
  logic [15:0]      max_ed_s;

  approx_mult_err_monitor #(.CNT_W(CNT_W), .SUM_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .win_len(win_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_r(in_r),
    .busy(busy), .done(done), .sample_cnt(sample_cnt), .err_cnt(err_cnt),
    .sum_ed(sum_ed), .max_ed(max_ed)
  );

  // Narrow accumulator copy used to exercise saturation
  approx_mult_err_monitor #(.CNT_W(CNT_W), .SUM_W(16)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .win_len(win_len),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_a(in_a), .in_b(in_b), .in_r(in_r),
    .busy(busy_s), .done(done_s), .sample_cnt(sample_cnt_s), .err_cnt(err_cnt_s),
    .sum_ed(sum_ed_s), .max_ed(max_ed_s)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [7:0]  va [4];
  logic [7:0]  vb [4];
  logic [15:0] vr [4];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Runs one window from a negedge; lat = negedge index of the cycle done is high
  task automatic run_window(input int n, input int gap, input logic [CNT_W-1:0] wl,
                            output int lat);
    start   = 1'b1;
    win_len = wl;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    for (int i = 0; i < n; i++) begin
      chk("ready_hi", in_ready, 1);
      in_valid = 1'b1;
      in_a = va[i];
      in_b = vb[i];
      in_r = vr[i];
      @(negedge clk);
      lat++;
      in_valid = 1'b0;
      in_a = 8'hA5;
      in_b = 8'h5A;
      in_r = 16'h1234;
      if (i < n - 1) begin
        repeat (gap) begin
          @(negedge clk);
          lat++;
        end
      end
    end
    chk("ready_drop", in_ready, 0);
    chk("busy_drain", busy, 1);
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic chk_stats(input string tag, input int c, input int e, input int s,
                           input int m);
    chk({tag, "_cnt"}, sample_cnt, c);
    chk({tag, "_err"}, err_cnt, e);
    chk({tag, "_sum"}, sum_ed, s);
    chk({tag, "_max"}, max_ed, m);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  lat;
    bit  saw_done;

    repeat (3) @(negedge clk);
    chk("rst_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk_stats("rst", 0, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic window: ED = 0, 6, 255
    va[0] = 8'd3;   vb[0] = 8'd5;   vr[0] = 16'd15;
    va[1] = 8'd16;  vb[1] = 8'd16;  vr[1] = 16'd250;
    va[2] = 8'd255; vb[2] = 8'd255; vr[2] = 16'hFF00;
    run_window(3, 0, 16'd3, lat);
    chk("basic_lat", lat, 6);
    chk_stats("basic", 3, 2, 261, 255);
    @(negedge clk);
    chk("basic_pulse", done, 0);
    chk("basic_idle", busy, 0);

    // Same window with two-cycle bubbles between samples
    run_window(3, 2, 16'd3, lat);
    chk("bubble_lat", lat, 10);
    chk_stats("bubble", 3, 2, 261, 255);
    @(negedge clk);
    chk("bubble_pulse", done, 0);

    // Zero-length window
    chk("zero_ready0", in_ready, 0);
    start   = 1'b1;
    win_len = 16'd0;
    @(negedge clk);
    start = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_ready1", in_ready, 0);
    chk_stats("zero", 0, 0, 0, 0);
    @(negedge clk);
    chk("zero_pulse", done, 0);
    chk("zero_ready2", in_ready, 0);

    // Saturation: two samples of ED = 65025
    va[0] = 8'd255; vb[0] = 8'd255; vr[0] = 16'd0;
    va[1] = 8'd255; vb[1] = 8'd255; vr[1] = 16'd0;
    run_window(2, 0, 16'd2, lat);
    chk("sat_lat", lat, 5);
    chk("sat_sum16", sum_ed_s, 16'hFFFF);
    chk("sat_max16", max_ed_s, 16'hFE01);
    chk("sat_err16", err_cnt_s, 2);
    chk("sat_sum32", sum_ed, 130050);
    @(negedge clk);

    // Start ignored in RUN and DRAIN; stats hold in IDLE
    start   = 1'b1;
    win_len = 16'd2;
    @(negedge clk);
    win_len = 16'd7;
    @(negedge clk);
    start = 1'b0;
    chk("ign_run_ready", in_ready, 1);
    in_valid = 1'b1; in_a = 8'd3; in_b = 8'd3; in_r = 16'd0;
    @(negedge clk);
    in_a = 8'd1; in_b = 8'd1; in_r = 16'd1;
    @(negedge clk);
    in_valid = 1'b0;
    start = 1'b1;
    chk("ign_drain1", busy, 1);
    chk("ign_drain1_ready", in_ready, 0);
    @(negedge clk);
    chk("ign_drain2", busy, 1);
    chk("ign_drain2_done", done, 0);
    @(negedge clk);
    start = 1'b0;
    chk("ign_done", done, 1);
    chk_stats("ign", 2, 1, 9, 9);
    repeat (10) @(negedge clk);
    chk("hold_busy", busy, 0);
    chk("hold_ready", in_ready, 0);
    chk_stats("hold", 2, 1, 9, 9);

    // Reset after the first of four samples
    start   = 1'b1;
    win_len = 16'd4;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; in_a = 8'd5; in_b = 8'd5; in_r = 16'd0;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_ready", in_ready, 0);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk_stats("mid", 0, 0, 0, 0);
    saw_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("mid_no_done", saw_done, 0);
    chk("mid_cnt_after", sample_cnt, 0);
    chk("mid_sum_after", sum_ed, 0);

    va[0] = 8'd2; vb[0] = 8'd2; vr[0] = 16'd4;
    run_window(1, 0, 16'd1, lat);
    chk("post_lat", lat, 4);
    chk_stats("post", 1, 0, 0, 0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
